// File: rtl/p_pmem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line traffic onto one
// shared physical-memory port. One transaction outstanding at a time; the
// winning request (address, op, write data) is captured at grant.
module p_pmem_arbiter #(
  parameter int unsigned s_line = 256,
  parameter int unsigned s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [s_line-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_addr-1:0] mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [s_line-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_d_q, prio_d_d;   // 1: D wins the next tie
  logic              grant_i, grant_d;
  logic [s_addr-1:0] addr_q;
  logic [s_line-1:0] wdata_q;
  logic              write_q;

  // State, priority and grant-time request capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      prio_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_d_q <= prio_d_d;
      if (grant_i) begin
        addr_q  <= i_pmem_address;
        write_q <= 1'b0;
      end else if (grant_d) begin
        addr_q  <= d_pmem_address;
        wdata_q <= d_pmem_wdata;
        write_q <= d_pmem_write;
      end
    end
  end

  // Arbitration, next state and port steering; client resp follows mem_resp
  always_comb begin
    state_d      = state_q;
    prio_d_d     = prio_d_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_rdata = '0;
    case (state_q)
      IDLE: begin
        if (i_pmem_read && !((d_pmem_read || d_pmem_write) && prio_d_q)) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end else if (d_pmem_read || d_pmem_write) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        mem_read     = !write_q;
        mem_write    = write_q;
        i_pmem_rdata = mem_rdata;
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          prio_d_d    = 1'b1;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        mem_read     = !write_q;
        mem_write    = write_q;
        d_pmem_rdata = mem_rdata;
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          prio_d_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
